// File: rtl/fu_dispatch.sv
// Issue-to-execute dispatch: routes one op per cycle to the X/Y/M unit output registers,
// tracking outstanding destination writes and per-unit in-flight ops to back-pressure Issue.
module fu_dispatch #(
  parameter int unsigned PAYLOAD_W    = 96,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 is_dp_valid,
  input  logic [1:0]           is_dp_fununit,
  input  logic [4:0]           is_dp_addra,
  input  logic [4:0]           is_dp_addrb,
  input  logic [4:0]           is_dp_regdest,
  input  logic                 is_dp_writereg,
  input  logic [PAYLOAD_W-1:0] is_dp_payload,
  output logic                 dp_is_ready,
  output logic                 dp_x_valid,
  output logic [PAYLOAD_W-1:0] dp_x_payload,
  output logic [4:0]           dp_x_regdest,
  input  logic                 x_dp_ready,
  input  logic                 x_dp_done,
  output logic                 dp_y_valid,
  output logic [PAYLOAD_W-1:0] dp_y_payload,
  output logic [4:0]           dp_y_regdest,
  input  logic                 y_dp_ready,
  input  logic                 y_dp_done,
  output logic                 dp_m_valid,
  output logic [PAYLOAD_W-1:0] dp_m_payload,
  output logic [4:0]           dp_m_regdest,
  input  logic                 m_dp_ready,
  input  logic                 m_dp_done,
  input  logic                 wb_dp_en,
  input  logic [4:0]           wb_dp_regdest,
  output logic                 dp_illegal,
  output logic [31:0]          dp_pending
);

  localparam int unsigned NUM_UNITS = 3;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned NUM_REGS  = 32;

  logic [NUM_UNITS-1:0]                valid_q, valid_d;
  logic [NUM_UNITS-1:0][PAYLOAD_W-1:0] payload_q, payload_d;
  logic [NUM_UNITS-1:0][REG_W-1:0]     regdest_q, regdest_d;
  logic [NUM_UNITS-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REGS-1:0]                 pending_q, pending_d;
  logic                                illegal_q, illegal_d;

  logic [NUM_UNITS-1:0] unit_ready;
  logic [NUM_UNITS-1:0] unit_done;
  logic [NUM_UNITS-1:0] slot_free;
  logic [NUM_UNITS-1:0] take;
  logic [NUM_UNITS-1:0] retire;
  logic                 illegal_op;
  logic                 hazard;
  logic                 unit_ok;
  logic                 accept;

  // Acceptance decision; hazard looks only at registered pending bits (no writeback bypass).
  always_comb begin
    unit_ready  = {m_dp_ready, y_dp_ready, x_dp_ready};
    unit_done   = {m_dp_done, y_dp_done, x_dp_done};
    illegal_op  = (is_dp_fununit == 2'd3);
    hazard      = pending_q[is_dp_addra] | pending_q[is_dp_addrb]
                | (is_dp_writereg & pending_q[is_dp_regdest]);
    slot_free   = ~valid_q | unit_ready;
    unit_ok     = 1'b0;
    for (int u = 0; u < int'(NUM_UNITS); u++) begin
      if (is_dp_fununit == 2'(u)) begin
        unit_ok = slot_free[u] & (cnt_q[u] < CNT_W'(MAX_INFLIGHT));
      end
    end
    dp_is_ready = !reset & (illegal_op | (unit_ok & !hazard));
    accept      = is_dp_valid & dp_is_ready;
    take        = '0;
    for (int u = 0; u < int'(NUM_UNITS); u++) begin
      take[u] = accept & !illegal_op & (is_dp_fununit == 2'(u));
    end
  end

  // Unit output registers and in-flight counters.
  always_comb begin
    valid_d   = valid_q & ~unit_ready;
    payload_d = payload_q;
    regdest_d = regdest_q;
    cnt_d     = cnt_q;
    retire    = '0;
    for (int u = 0; u < int'(NUM_UNITS); u++) begin
      if (take[u]) begin
        valid_d[u]   = 1'b1;
        payload_d[u] = is_dp_payload;
        regdest_d[u] = is_dp_writereg ? is_dp_regdest : '0;
      end
      // A done with nothing in flight is dropped rather than wrapping the counter.
      retire[u] = unit_done[u] & (cnt_q[u] != '0);
      if (take[u] && !retire[u]) begin
        cnt_d[u] = cnt_q[u] + CNT_W'(1);
      end else if (!take[u] && retire[u]) begin
        cnt_d[u] = cnt_q[u] - CNT_W'(1);
      end
    end
  end

  // Scoreboard: clear on writeback first so a same-cycle new claim on that register wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_dp_en) begin
      pending_d[wb_dp_regdest] = 1'b0;
    end
    if (accept && !illegal_op && is_dp_writereg && (is_dp_regdest != '0)) begin
      pending_d[is_dp_regdest] = 1'b1;
    end
    pending_d[0] = 1'b0;
    illegal_d    = accept & illegal_op;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= '0;
      payload_q <= '0;
      regdest_q <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      regdest_q <= regdest_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      illegal_q <= illegal_d;
    end
  end

  assign dp_x_valid   = valid_q[0];
  assign dp_x_payload = payload_q[0];
  assign dp_x_regdest = regdest_q[0];
  assign dp_y_valid   = valid_q[1];
  assign dp_y_payload = payload_q[1];
  assign dp_y_regdest = regdest_q[1];
  assign dp_m_valid   = valid_q[2];
  assign dp_m_payload = payload_q[2];
  assign dp_m_regdest = regdest_q[2];
  assign dp_illegal   = illegal_q;
  assign dp_pending   = pending_q;

endmodule

// File: tb/tb_fu_dispatch.sv
// Bench for fu_dispatch: vector table for acceptance/scoreboard behaviour, hand sequences for
// unit back-pressure and reset flush; per-unit queues check every op delivered to a unit.
module tb_fu_dispatch;

  localparam int unsigned PW = 96;

  logic          clock = 1'b0;
  logic          reset;
  logic          is_dp_valid;
  logic [1:0]    is_dp_fununit;
  logic [4:0]    is_dp_addra, is_dp_addrb, is_dp_regdest;
  logic          is_dp_writereg;
  logic [PW-1:0] is_dp_payload;
  logic          dp_is_ready;
  logic          dp_x_valid, dp_y_valid, dp_m_valid;
  logic [PW-1:0] dp_x_payload, dp_y_payload, dp_m_payload;
  logic [4:0]    dp_x_regdest, dp_y_regdest, dp_m_regdest;
  logic          x_dp_ready, y_dp_ready, m_dp_ready;
  logic          x_dp_done, y_dp_done, m_dp_done;
  logic          wb_dp_en;
  logic [4:0]    wb_dp_regdest;
  logic          dp_illegal;
  logic [31:0]   dp_pending;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fu_dispatch #(.PAYLOAD_W(PW), .MAX_INFLIGHT(2)) dut (
    .clock(clock), .reset(reset),
    .is_dp_valid(is_dp_valid), .is_dp_fununit(is_dp_fununit),
    .is_dp_addra(is_dp_addra), .is_dp_addrb(is_dp_addrb),
    .is_dp_regdest(is_dp_regdest), .is_dp_writereg(is_dp_writereg),
    .is_dp_payload(is_dp_payload), .dp_is_ready(dp_is_ready),
    .dp_x_valid(dp_x_valid), .dp_x_payload(dp_x_payload), .dp_x_regdest(dp_x_regdest),
    .x_dp_ready(x_dp_ready), .x_dp_done(x_dp_done),
    .dp_y_valid(dp_y_valid), .dp_y_payload(dp_y_payload), .dp_y_regdest(dp_y_regdest),
    .y_dp_ready(y_dp_ready), .y_dp_done(y_dp_done),
    .dp_m_valid(dp_m_valid), .dp_m_payload(dp_m_payload), .dp_m_regdest(dp_m_regdest),
    .m_dp_ready(m_dp_ready), .m_dp_done(m_dp_done),
    .wb_dp_en(wb_dp_en), .wb_dp_regdest(wb_dp_regdest),
    .dp_illegal(dp_illegal), .dp_pending(dp_pending)
  );

  typedef struct {
    logic [1:0]  fu;
    logic [4:0]  ra, rb, rd;
    logic        wr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [2:0]  rdy;        // {m,y,x}
    logic [2:0]  done;       // {m,y,x}
    logic        exp_rdy;
    logic [31:0] exp_pend;
    logic [2:0]  exp_valid;  // {m,y,x}
  } vec_t;

  typedef struct {
    logic [PW-1:0] payload;
    logic [4:0]    regdest;
  } exp_t;

  vec_t vecs[15];
  exp_t q_x[$];
  exp_t q_y[$];
  exp_t q_m[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] fu, input logic [4:0] ra, input logic [4:0] rb,
                              input logic [4:0] rd, input logic wr, input logic wb_en,
                              input logic [4:0] wb_rd, input logic [2:0] rdy,
                              input logic [2:0] done, input logic exp_rdy,
                              input logic [31:0] exp_pend, input logic [2:0] exp_valid);
    vec_t v;
    v.fu = fu; v.ra = ra; v.rb = rb; v.rd = rd; v.wr = wr;
    v.wb_en = wb_en; v.wb_rd = wb_rd; v.rdy = rdy; v.done = done;
    v.exp_rdy = exp_rdy; v.exp_pend = exp_pend; v.exp_valid = exp_valid;
    return v;
  endfunction

  function automatic logic [PW-1:0] pay(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'(i) * 32'h0101_0101, 32'hFACE_0000 ^ 32'(i)};
  endfunction

  task automatic push(input logic [1:0] u, input logic [PW-1:0] p, input logic [4:0] r);
    exp_t e;
    e.payload = p;
    e.regdest = r;
    case (u)
      2'd0:    q_x.push_back(e);
      2'd1:    q_y.push_back(e);
      default: q_m.push_back(e);
    endcase
  endtask

  task automatic pop_chk(input int u, input logic [PW-1:0] p, input logic [4:0] r);
    exp_t e;
    logic have;
    have = 1'b0;
    e.payload = '0;
    e.regdest = '0;
    case (u)
      0: if (q_x.size() > 0) begin e = q_x.pop_front(); have = 1'b1; end
      1: if (q_y.size() > 0) begin e = q_y.pop_front(); have = 1'b1; end
      default: if (q_m.size() > 0) begin e = q_m.pop_front(); have = 1'b1; end
    endcase
    chk($sformatf("sb_expected_op_u%0d", u), 128'(have), 128'(1'b1));
    if (have) begin
      chk($sformatf("sb_payload_u%0d", u), 128'(p), 128'(e.payload));
      chk($sformatf("sb_regdest_u%0d", u), 128'(r), 128'(e.regdest));
    end
  endtask

  // A unit takes its op on the edge after a negedge where valid & ready are both high.
  always @(negedge clock) begin
    if (!reset) begin
      if (dp_x_valid && x_dp_ready) pop_chk(0, dp_x_payload, dp_x_regdest);
      if (dp_y_valid && y_dp_ready) pop_chk(1, dp_y_payload, dp_y_regdest);
      if (dp_m_valid && m_dp_ready) pop_chk(2, dp_m_payload, dp_m_regdest);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] fu, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [4:0] rd, input logic wr, input logic [PW-1:0] p);
    is_dp_valid    = 1'b1;
    is_dp_fununit  = fu;
    is_dp_addra    = ra;
    is_dp_addrb    = rb;
    is_dp_regdest  = rd;
    is_dp_writereg = wr;
    is_dp_payload  = p;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    is_dp_valid = 1'b0;
    cyc();
    reset = 1'b0;
    q_x.delete();
    q_y.delete();
    q_m.delete();
  endtask

  task automatic chk_queues_empty(input string name);
    chk({name, "_x_left"}, 128'(q_x.size()), 128'(0));
    chk({name, "_y_left"}, 128'(q_y.size()), 128'(0));
    chk({name, "_m_left"}, 128'(q_m.size()), 128'(0));
  endtask

  initial begin
    vec_t v;
    logic [PW-1:0] p1, p2, p3;

    reset = 1'b1;
    drive_op(2'd3, 5'd0, 5'd0, 5'd0, 1'b0, '0);
    {x_dp_ready, y_dp_ready, m_dp_ready} = 3'b111;
    {x_dp_done, y_dp_done, m_dp_done}    = 3'b000;
    wb_dp_en      = 1'b0;
    wb_dp_regdest = '0;

    // Reset state; an illegal op presented during reset must not be accepted.
    cyc();
    chk("ready_during_reset", 128'(dp_is_ready), 128'(1'b0));
    cyc();
    reset       = 1'b0;
    is_dp_valid = 1'b0;
    chk("reset_valids", 128'({dp_m_valid, dp_y_valid, dp_x_valid}), 128'(3'b000));
    chk("reset_pending", 128'(dp_pending), 128'(32'h0));
    chk("reset_illegal", 128'(dp_illegal), 128'(1'b0));
    chk("reset_x_payload", 128'(dp_x_payload), 128'(0));
    chk("reset_y_regdest", 128'(dp_y_regdest), 128'(5'd0));

    //             fu    ra  rb  rd  wr  wb  wbrd rdy     done    rdy  pend          valid
    vecs[0]  = mk(2'd0, 0,  0,  5,  1,  0,  0,  3'b111, 3'b000, 1,  32'h0000_0020, 3'b001);
    vecs[1]  = mk(2'd0, 5,  0,  6,  1,  0,  0,  3'b111, 3'b001, 0,  32'h0000_0020, 3'b000);
    vecs[2]  = mk(2'd0, 5,  0,  6,  1,  1,  5,  3'b111, 3'b000, 0,  32'h0000_0000, 3'b000);
    vecs[3]  = mk(2'd0, 5,  0,  6,  1,  0,  0,  3'b111, 3'b000, 1,  32'h0000_0040, 3'b001);
    vecs[4]  = mk(2'd1, 0,  0,  7,  1,  1,  7,  3'b111, 3'b000, 1,  32'h0000_00C0, 3'b010);
    vecs[5]  = mk(2'd2, 0,  0,  6,  0,  0,  0,  3'b111, 3'b000, 1,  32'h0000_00C0, 3'b100);
    vecs[6]  = mk(2'd3, 6,  7,  6,  1,  0,  0,  3'b111, 3'b111, 1,  32'h0000_00C0, 3'b000);
    vecs[7]  = mk(2'd0, 0,  0,  0,  1,  1,  6,  3'b111, 3'b000, 1,  32'h0000_0080, 3'b001);
    vecs[8]  = mk(2'd0, 0,  0,  0,  0,  0,  0,  3'b110, 3'b000, 0,  32'h0000_0080, 3'b001);
    vecs[9]  = mk(2'd0, 0,  0,  0,  0,  0,  0,  3'b111, 3'b000, 1,  32'h0000_0080, 3'b001);
    vecs[10] = mk(2'd0, 0,  0,  0,  0,  0,  0,  3'b111, 3'b000, 0,  32'h0000_0080, 3'b000);
    vecs[11] = mk(2'd0, 0,  0,  0,  0,  0,  0,  3'b111, 3'b001, 0,  32'h0000_0080, 3'b000);
    vecs[12] = mk(2'd0, 0,  0,  0,  0,  1,  7,  3'b111, 3'b000, 1,  32'h0000_0000, 3'b001);
    vecs[13] = mk(2'd1, 0,  7,  8,  0,  0,  0,  3'b111, 3'b100, 1,  32'h0000_0000, 3'b010);
    vecs[14] = mk(2'd2, 0,  0,  9,  1,  0,  0,  3'b111, 3'b010, 1,  32'h0000_0200, 3'b100);

    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      drive_op(v.fu, v.ra, v.rb, v.rd, v.wr, pay(i));
      wb_dp_en      = v.wb_en;
      wb_dp_regdest = v.wb_rd;
      {m_dp_ready, y_dp_ready, x_dp_ready} = v.rdy;
      {m_dp_done, y_dp_done, x_dp_done}    = v.done;
      #1;
      chk($sformatf("v%0d_ready", i), 128'(dp_is_ready), 128'(v.exp_rdy));
      if (v.exp_rdy && v.fu != 2'd3) push(v.fu, pay(i), v.wr ? v.rd : 5'd0);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_pending", i), 128'(dp_pending), 128'(v.exp_pend));
      chk($sformatf("v%0d_valids", i), 128'({dp_m_valid, dp_y_valid, dp_x_valid}),
          128'(v.exp_valid));
      chk($sformatf("v%0d_illegal", i), 128'(dp_illegal),
          128'(v.exp_rdy && v.fu == 2'd3));
    end

    is_dp_valid = 1'b0;
    wb_dp_en    = 1'b0;
    {x_dp_ready, y_dp_ready, m_dp_ready} = 3'b111;
    {x_dp_done, y_dp_done, m_dp_done}    = 3'b000;
    cyc();
    cyc();
    chk_queues_empty("table");

    // Y unit stalled: first op parks in the slot, second waits, then in-flight limit bites.
    do_reset();
    y_dp_ready = 1'b0;
    p1 = pay(101);
    p2 = pay(102);
    p3 = pay(103);
    drive_op(2'd1, 5'd0, 5'd0, 5'd0, 1'b0, p1);
    #1;
    chk("y_op1_ready", 128'(dp_is_ready), 128'(1'b1));
    push(2'd1, p1, 5'd0);
    cyc();
    drive_op(2'd1, 5'd0, 5'd0, 5'd0, 1'b0, p2);
    #1;
    chk("y_op2_stall", 128'(dp_is_ready), 128'(1'b0));
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("y_hold_payload", 128'(dp_y_payload), 128'(p1));
      chk("y_hold_valid", 128'(dp_y_valid), 128'(1'b1));
      chk("y_hold_ready", 128'(dp_is_ready), 128'(1'b0));
    end
    y_dp_ready = 1'b1;
    #1;
    chk("y_op2_drain_refill", 128'(dp_is_ready), 128'(1'b1));
    push(2'd1, p2, 5'd0);
    cyc();
    chk("y_op2_in_slot", 128'(dp_y_payload), 128'(p2));
    drive_op(2'd1, 5'd0, 5'd0, 5'd0, 1'b0, p3);
    #1;
    chk("y_op3_limit", 128'(dp_is_ready), 128'(1'b0));
    cyc();
    y_dp_done = 1'b1;
    #1;
    chk("y_op3_done_not_yet", 128'(dp_is_ready), 128'(1'b0));
    cyc();
    y_dp_done = 1'b0;
    #1;
    chk("y_op3_after_done", 128'(dp_is_ready), 128'(1'b1));
    push(2'd1, p3, 5'd0);
    cyc();
    is_dp_valid = 1'b0;
    cyc();
    chk_queues_empty("ystall");

    // Reset with X and M slots occupied and r5/r7 pending flushes everything.
    do_reset();
    x_dp_ready = 1'b0;
    m_dp_ready = 1'b0;
    drive_op(2'd0, 5'd0, 5'd0, 5'd5, 1'b1, pay(201));
    #1;
    chk("flush_x_ready", 128'(dp_is_ready), 128'(1'b1));
    push(2'd0, pay(201), 5'd5);
    cyc();
    drive_op(2'd2, 5'd0, 5'd0, 5'd7, 1'b1, pay(202));
    #1;
    chk("flush_m_ready", 128'(dp_is_ready), 128'(1'b1));
    push(2'd2, pay(202), 5'd7);
    cyc();
    is_dp_valid = 1'b0;
    chk("flush_pre_pending", 128'(dp_pending), 128'(32'h0000_00A0));
    chk("flush_pre_valids", 128'({dp_m_valid, dp_y_valid, dp_x_valid}), 128'(3'b101));
    chk("flush_pre_m_regdest", 128'(dp_m_regdest), 128'(5'd7));
    reset = 1'b1;
    #1;
    chk("flush_ready_in_reset", 128'(dp_is_ready), 128'(1'b0));
    cyc();
    reset = 1'b0;
    q_x.delete();
    q_m.delete();
    chk("flush_valids", 128'({dp_m_valid, dp_y_valid, dp_x_valid}), 128'(3'b000));
    chk("flush_pending", 128'(dp_pending), 128'(32'h0));
    chk("flush_x_payload", 128'(dp_x_payload), 128'(0));
    chk("flush_m_regdest", 128'(dp_m_regdest), 128'(5'd0));
    chk("flush_illegal", 128'(dp_illegal), 128'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
